// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, HCount/VCount counters and registered sync/visible/frame decodes.
// Latency: all outputs are registered and change on the same edge as the counters; the first tick lands CLK_DIV clks after start.
// No backpressure: free-running once enabled; sync_en low parks every register at the last blank pixel of the frame.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync_en,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_hcount;
  logic [9:0]       r_vcount;
  logic             r_hsync_n;
  logic             r_vsync_n;
  logic             r_video_on;
  logic             r_pixel_tick;
  logic             r_frame_start;

  logic             w_tick;
  logic [9:0]       w_hnext;
  logic [9:0]       w_vnext;

  // The tick fires on the last clk of each divider period (every clk when CLK_DIV=1).
  assign w_tick = (r_div == DIV_LAST);

  // Next raster position: advance one pixel per tick, wrapping line then frame together.
  always_comb begin
    w_hnext = r_hcount;
    w_vnext = r_vcount;
    if (w_tick) begin
      if (r_hcount == H_LAST) begin
        w_hnext = 10'd0;
        w_vnext = (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
      end else begin
        w_hnext = r_hcount + 10'd1;
      end
    end
  end

  // State update; decodes use the next-state position so they carry no skew against the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_hcount      <= H_LAST;
      r_vcount      <= V_LAST;
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_video_on    <= 1'b0;
      r_pixel_tick  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (!sync_en) begin
      // Park at the last blank pixel so re-enabling begins a clean frame.
      r_div         <= '0;
      r_hcount      <= H_LAST;
      r_vcount      <= V_LAST;
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_video_on    <= 1'b0;
      r_pixel_tick  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_tick ? '0 : r_div + DIV_ONE;
      r_hcount      <= w_hnext;
      r_vcount      <= w_vnext;
      r_hsync_n     <= !((w_hnext >= HS_START) && (w_hnext < HS_END));
      r_vsync_n     <= !((w_vnext >= VS_START) && (w_vnext < VS_END));
      r_video_on    <= (w_hnext < H_VIS) && (w_vnext < V_VIS);
      r_pixel_tick  <= w_tick;
      // Qualified by the tick so it marks only the first clk of pixel (0,0).
      r_frame_start <= w_tick && (w_hnext == 10'd0) && (w_vnext == 10'd0);
    end
  end

  assign HCount      = r_hcount;
  assign VCount      = r_vcount;
  assign hsync_n     = r_hsync_n;
  assign vsync_n     = r_vsync_n;
  assign video_on    = r_video_on;
  assign pixel_tick  = r_pixel_tick;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       pt;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sync_en = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   c = 0;            // enabled clk edges since the last reset/disable

  always #5 clk = ~clk;

  // Three instances: full VGA timing, a shrunk raster with CLK_DIV=3, and the same raster with CLK_DIV=1.
  logic [9:0] dh, dv, sh, sv, oh, ov;
  logic dhs, dvs, dvo, dpt, dfs, shs, svs, svo, spt, sfs, ohs, ovs, ovo, opt, ofs;

  vga_sync_gen u_def (
    .clk(clk), .rst_n(rst_n), .sync_en(sync_en), .HCount(dh), .VCount(dv),
    .hsync_n(dhs), .vsync_n(dvs), .video_on(dvo), .pixel_tick(dpt), .frame_start(dfs));

  vga_sync_gen #(.CLK_DIV(3), .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
                 .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) u_small (
    .clk(clk), .rst_n(rst_n), .sync_en(sync_en), .HCount(sh), .VCount(sv),
    .hsync_n(shs), .vsync_n(svs), .video_on(svo), .pixel_tick(spt), .frame_start(sfs));

  vga_sync_gen #(.CLK_DIV(1), .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
                 .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) u_div1 (
    .clk(clk), .rst_n(rst_n), .sync_en(sync_en), .HCount(oh), .VCount(ov),
    .hsync_n(ohs), .vsync_n(ovs), .video_on(ovo), .pixel_tick(opt), .frame_start(ofs));

  exp_t got_def, got_small, got_div1;
  assign got_def   = {dh, dv, dhs, dvs, dvo, dpt, dfs};
  assign got_small = {sh, sv, shs, svs, svo, spt, sfs};
  assign got_div1  = {oh, ov, ohs, ovs, ovo, opt, ofs};

  // Reference: after c enabled clks there have been c/div ticks; tick n>=1 shows linear pixel n-1 of the frame.
  function automatic exp_t model(input int cc, input int div, input int hd, input int hf, input int hsw,
                                 input int hb, input int vd, input int vf, input int vsw, input int vb);
    int   ht, vt, n, l, h, v;
    exp_t e;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    n  = cc / div;
    if (n == 0) begin
      h = ht - 1; v = vt - 1; l = -1;
    end else begin
      l = (n - 1) % (ht * vt);
      h = l % ht;
      v = l / ht;
    end
    e.h  = 10'(h);
    e.v  = 10'(v);
    e.hs = !((h >= hd + hf) && (h < hd + hf + hsw));
    e.vs = !((v >= vd + vf) && (v < vd + vf + vsw));
    e.vo = (h < hd) && (v < vd);
    e.pt = (cc > 0) && (cc % div == 0);
    e.fs = e.pt && (l == 0);
    return e;
  endfunction

  function automatic exp_t m_def(input int cc);
    return model(cc, 2, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction
  function automatic exp_t m_small(input int cc);
    return model(cc, 3, 20, 3, 4, 5, 10, 2, 2, 3);
  endfunction
  function automatic exp_t m_div1(input int cc);
    return model(cc, 1, 20, 3, 4, 5, 10, 2, 2, 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h (c=%0d t=%0t)", name, got, exp, c, $time);
    end
  endtask

  // Enabled-edge counter driven by the same stimulus the DUTs see.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        c <= 0;
    else if (!sync_en) c <= 0;
    else               c <= c + 1;
  end

  // Per-cycle compare, plus line-period and frame-period spacing checks.
  int last_hs_fall = -1;
  int last_fs      = -1;
  logic prev_dhs   = 1'b1;
  always @(negedge clk) begin
    chk("def_outputs",   32'(got_def),   32'(m_def(c)));
    chk("small_outputs", 32'(got_small), 32'(m_small(c)));
    chk("div1_outputs",  32'(got_div1),  32'(m_div1(c)));
    if (c == 0) begin
      last_hs_fall = -1;
      last_fs      = -1;
    end else begin
      if (prev_dhs && !dhs) begin
        if (last_hs_fall >= 0) chk("def_line_period", 32'(c - last_hs_fall), 32'd1600);
        last_hs_fall = c;
      end
      if (sfs) begin
        if (last_fs >= 0) chk("small_frame_period", 32'(c - last_fs), 32'd1632);
        last_fs = c;
      end
    end
    prev_dhs = dhs;
  end

  task automatic run(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hcount"}, 32'(dh), 32'd799);
    chk({tag, "_vcount"}, 32'(dv), 32'd524);
    chk({tag, "_syncs"},  32'({dhs, dvs}), 32'b11);
    chk({tag, "_vo_pt_fs"}, 32'({dvo, dpt, dfs}), 32'b000);
  endtask

  initial begin
    exp_t e;
    int   guard;

    // Model pinned against hand-computed values.
    e = m_def(2);
    chk("model_first_pixel", 32'({e.h, e.v, e.vo, e.pt, e.fs}), 32'({10'd0, 10'd0, 3'b111}));
    e = m_def(1314);
    chk("model_hs_fall", 32'({e.h, e.hs}), 32'({10'd656, 1'b0}));
    e = m_def(1504);
    chk("model_hs_last", 32'({e.h, e.hs}), 32'({10'd751, 1'b0}));
    e = m_def(1506);
    chk("model_hs_rise", 32'({e.h, e.hs}), 32'({10'd752, 1'b1}));
    e = m_def(480 * 1600 + 2);
    chk("model_no_video_v480", 32'({e.v, e.vo}), 32'({10'd480, 1'b0}));
    e = m_def(490 * 1600 + 2);
    chk("model_vsync", 32'({e.v, e.vs}), 32'({10'd490, 1'b0}));
    e = m_small(1632 + 3);
    chk("model_small_wrap", 32'({e.h, e.v, e.fs}), 32'({10'd0, 10'd0, 1'b1}));

    // Power-on reset and release.
    #1 rst_n = 1'b0;
    run(3);
    check_reset_vals("in_reset");
    rst_n = 1'b1;
    run(1);
    chk("rel_edge1_tick", 32'({dpt, dh}), 32'({1'b0, 10'd799}));
    run(1);
    chk("rel_edge2_pos", 32'({dh, dv}), 32'd0);
    chk("rel_edge2_flags", 32'({dpt, dfs, dvo}), 32'b111);
    run(1);
    chk("rel_edge3_fs_once", 32'({dpt, dfs, dh}), 32'({1'b0, 1'b0, 10'd0}));

    // Let both rasters run: several short frames and two full-VGA lines.
    run(3500);

    // Drop sync_en while the default raster sits inside its hsync pulse.
    guard = 0;
    while (dh != 10'd700 && guard < 4000) begin
      run(1);
      guard++;
    end
    chk("wait_hcount_700", 32'(guard < 4000), 32'd1);
    chk("hsync_low_at_700", 32'(dhs), 32'd0);
    sync_en = 1'b0;
    run(1);
    check_reset_vals("sync_en_drop");
    run(4);
    check_reset_vals("sync_en_hold");
    sync_en = 1'b1;
    run(1);
    chk("reen_edge1_fs", 32'(dfs), 32'd0);
    run(1);
    chk("reen_edge2_fs", 32'({dfs, dh, dv}), 32'({1'b1, 10'd0, 10'd0}));
    run(1200);

    // Asynchronous reset between edges must act immediately.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    chk("async_rst_small", 32'({sh, sv}), 32'({10'd31, 10'd16}));
    run(2);
    rst_n = 1'b1;

    // Randomised disruptions: disable pulses and async resets at random phases.
    for (int k = 0; k < 20; k++) begin
      run($urandom_range(400, 30));
      if ($urandom_range(1, 0) == 1) begin
        sync_en = 1'b0;
        run($urandom_range(5, 1));
        sync_en = 1'b1;
      end else begin
        @(posedge clk);
        #($urandom_range(4, 1)) rst_n = 1'b0;
        run($urandom_range(3, 1));
        rst_n = 1'b1;
      end
    end
    run(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing generator that drives the `HCount`/`VCount` raster bus consumed by the card renderers and the other pixel-generation blocks.
- Produces VGA 640x480@60 sync pulses, a visible-area flag, a pixel-rate strobe and a frame-start pulse.
- Sits between the board clock and the display pipeline. Every card renderer compares its pixel window against these counters.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz clk -> 25 MHz pixel rate); integer >= 1
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sync_en  input  1  run enable; low holds the generator in its reset position
- HCount  output  10  current pixel column, 0..H_TOTAL-1
- VCount  output  10  current line, 0..V_TOTAL-1
- hsync_n  output  1  horizontal sync, active low
- vsync_n  output  1  vertical sync, active low
- video_on  output  1  high while (HCount, VCount) is in the visible area
- pixel_tick  output  1  one-clk strobe, once per CLK_DIV clks
- frame_start  output  1  one-clk pulse on the first clk of pixel (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK = 525
- Reset, asserted asynchronously whenever rst_n=0:
  - div counter = 0
  - HCount = H_TOTAL-1 (799), VCount = V_TOTAL-1 (524)
  - hsync_n = 1, vsync_n = 1
  - video_on = 0, pixel_tick = 0, frame_start = 0
- The reset position is deliberately the last blank pixel of the frame, so the first tick wraps to (0,0) and pulses frame_start.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pixel_tick is registered and high for exactly one clk every CLK_DIV clks.
  - The first pixel_tick occurs CLK_DIV clks after reset release, or after sync_en rises.
  - CLK_DIV=1 makes pixel_tick constantly high.
- Counters advance only on the clk edge where the tick condition holds:
  - HCount = HCount+1.
  - If HCount = H_TOTAL-1, HCount wraps to 0 and VCount = VCount+1.
  - If VCount is also V_TOTAL-1, VCount wraps to 0.
  - Counters are never out of range.
- Decoded outputs are registered from the next-state counter values, so they change on the same edge as the counters (zero skew against HCount/VCount):
  - hsync_n = 0 iff H_DISPLAY+H_FRONT <= HCount <= H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751.
  - vsync_n = 0 iff V_DISPLAY+V_FRONT <= VCount <= V_DISPLAY+V_FRONT+V_SYNC-1, i.e. 490..491.
  - video_on = 1 iff HCount < H_DISPLAY and VCount < V_DISPLAY.
  - frame_start = 1 for exactly one clk: the first clk in which (HCount, VCount) = (0,0). It does not repeat for the remaining CLK_DIV-1 clks of that pixel.
- sync_en = 0, synchronous: on the next edge, all registers take the reset values above.
  - The block stays there while sync_en is low.
  - Re-enabling starts a clean frame with frame_start.
- sync_en deasserted mid-line or mid-sync pulse: sync outputs return high on the next edge. No partial pulse continues.
- Simultaneous tick with end of line and end of frame: H and V wrap on the same edge, VCount -> 0, frame_start asserted.
- All outputs are glitch-free registers. No combinational path from inputs to outputs.

Test Plan:
- Reset value check: hold rst_n=0, then release.
  - During reset: HCount=799, VCount=524, hsync_n=vsync_n=1, video_on=0.
  - First pixel_tick 2 clks after release.
  - On that edge: counters become (0,0), video_on=1, frame_start high for 1 clk.
- Line timing, CLK_DIV=2:
  - Line period 1600 clks; video_on high for 1280 clks per visible line.
  - hsync_n falls when HCount=656 and stays low 192 clks, rising at HCount=752.
- Frame timing:
  - Frame period 840000 clks; frame_start spacing exactly 840000 clks.
  - vsync_n low from VCount=490 through 491 (3200 clks).
  - video_on never high for VCount>=480.
- Wrap corner: at (799,524) on a tick -> next (0,0) on the same edge. Assert HCount<800 and VCount<525 on every clk.
- sync_en dropped while HCount=700 (hsync low):
  - Next edge: hsync_n=1 and counters=(799,524).
  - Re-raise: frame_start 2 clks later.
- Async reset mid-frame, with rst_n asserted between clk edges: outputs take their reset values immediately, without waiting for a clk edge.
